// File: rtl/mux_4x1_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux_4x1_rr_arbiter
// Brief    : Four-way round-robin arbiter with a bounded hold time. It drives
//            a 4:1 data mux from the registered index of the current grantee.
// Revision : 1.0 - initial release
// ============================================================================
module mux_4x1_rr_arbiter #(
    parameter int WIDTH    = 1,
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    output logic [3:0]       gnt,
    output logic [1:0]       sel,
    output logic             valid,
    output logic [WIDTH-1:0] y
);

    localparam logic [0:0] C_ST_IDLE   = 1'b0;
    localparam logic [0:0] C_ST_BUSY   = 1'b1;
    // Last hold count before the grantee must yield to a competitor.
    localparam logic [7:0] C_HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [0:0] r_state;
    logic [3:0] r_gnt;
    logic [1:0] r_sel;
    logic       r_valid;
    logic [1:0] r_ptr;
    logic [7:0] r_hold_cnt;

    logic [0:0] w_state;
    logic [3:0] w_gnt;
    logic [1:0] w_sel;
    logic       w_valid;
    logic [1:0] w_ptr;
    logic [7:0] w_hold_cnt;

    logic [1:0] w_pick;
    logic [1:0] w_idx;
    logic       w_grant;
    logic       w_owner_req;
    logic       w_others;

    // Rotating-priority search: first requester at ptr, ptr+1, ptr+2, ptr+3.
    // Scanning from the far end lets the nearest hit overwrite earlier ones.
    always_comb begin
        w_pick = r_ptr;
        w_idx  = r_ptr;
        for (int k = 3; k >= 0; k--) begin
            w_idx = r_ptr + 2'(k);
            if (req[w_idx]) begin
                w_pick = w_idx;
            end
        end
    end

    assign w_owner_req = |(req & r_gnt);
    assign w_others    = |(req & ~r_gnt);

    // Next-state and next-output decode for the IDLE/BUSY controller.
    always_comb begin
        w_state    = r_state;
        w_gnt      = r_gnt;
        w_sel      = r_sel;
        w_valid    = r_valid;
        w_ptr      = r_ptr;
        w_hold_cnt = r_hold_cnt;
        w_grant    = 1'b0;

        case (r_state)
            C_ST_IDLE: begin
                if (|req) begin
                    w_grant = 1'b1;
                end
            end
            C_ST_BUSY: begin
                if (!w_owner_req) begin
                    // Owner released: hand over on this edge or fall idle.
                    if (|req) begin
                        w_grant = 1'b1;
                    end else begin
                        w_state = C_ST_IDLE;
                        w_gnt   = 4'b0000;
                        w_valid = 1'b0;
                    end
                end else if (r_hold_cnt < C_HOLD_LAST) begin
                    w_hold_cnt = r_hold_cnt + 8'd1;
                end else if (w_others) begin
                    // Hold budget spent; ptr already points past the owner,
                    // so the search lands on a competitor.
                    w_grant = 1'b1;
                end
                // Otherwise keep the grant with hold_cnt saturated.
            end
            default: begin
                w_state = C_ST_IDLE;
                w_gnt   = 4'b0000;
                w_valid = 1'b0;
            end
        endcase

        if (w_grant) begin
            w_state    = C_ST_BUSY;
            w_gnt      = 4'b0001 << w_pick;
            w_sel      = w_pick;
            w_valid    = 1'b1;
            w_ptr      = w_pick + 2'd1;
            w_hold_cnt = 8'd0;
        end
    end

    // State register; reset clears the grant immediately, independent of clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= C_ST_IDLE;
            r_gnt      <= 4'b0000;
            r_sel      <= 2'd0;
            r_valid    <= 1'b0;
            r_ptr      <= 2'd0;
            r_hold_cnt <= 8'd0;
        end else begin
            r_state    <= w_state;
            r_gnt      <= w_gnt;
            r_sel      <= w_sel;
            r_valid    <= w_valid;
            r_ptr      <= w_ptr;
            r_hold_cnt <= w_hold_cnt;
        end
    end

    // Shared output mux follows the registered select.
    always_comb begin
        case (sel)
            2'd0:    y = a;
            2'd1:    y = b;
            2'd2:    y = c;
            default: y = d;
        endcase
    end

    assign gnt   = r_gnt;
    assign sel   = r_sel;
    assign valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_mux_4x1_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_4x1_rr_arbiter
// Brief    : Scoreboard bench for mux_4x1_rr_arbiter (WIDTH=8, MAX_HOLD=4)
//            with directed sequences followed by randomized request traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_4x1_rr_arbiter;

    localparam int WIDTH    = 8;
    localparam int MAX_HOLD = 4;

    logic             clk;
    logic             rst_n;
    logic [3:0]       req;
    logic [WIDTH-1:0] a, b, c, d;
    logic [3:0]       gnt;
    logic [1:0]       sel;
    logic             valid;
    logic [WIDTH-1:0] y;

    mux_4x1_rr_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .a     (a),
        .b     (b),
        .c     (c),
        .d     (d),
        .gnt   (gnt),
        .sel   (sel),
        .valid (valid),
        .y     (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]       gnt;
        logic [1:0]       sel;
        logic             valid;
        logic [WIDTH-1:0] y;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: who owns the output, where the search starts, how
    // long the owner has held it, and the most recent select.
    int               m_g    = -1;
    int               m_ptr  = 0;
    int               m_held = 0;
    int               m_sel  = 0;
    logic [WIDTH-1:0] dat[4];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [3:0] r);
        for (int k = 0; k < 4; k++) begin
            if (r[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_grant(input int p);
        m_g    = p;
        m_sel  = p;
        m_ptr  = (p + 1) % 4;
        m_held = 0;
    endtask

    task automatic model_step(input logic [3:0] r);
        int p;
        p = pick(r);
        if (m_g < 0) begin
            if (r != 4'b0) model_grant(p);
        end else if (!r[m_g]) begin
            if (r != 4'b0) model_grant(p);
            else m_g = -1;
        end else if (m_held < MAX_HOLD - 1) begin
            m_held++;
        end else if ((r & ~(4'b0001 << m_g)) != 4'b0) begin
            model_grant(p);
        end
    endtask

    task automatic model_reset();
        m_g    = -1;
        m_ptr  = 0;
        m_held = 0;
        m_sel  = 0;
    endtask

    // Drive inputs now and queue what the DUT must show after the next edge.
    task automatic apply(input logic [3:0] r, input logic [WIDTH-1:0] da,
                         input logic [WIDTH-1:0] db, input logic [WIDTH-1:0] dc,
                         input logic [WIDTH-1:0] dd);
        exp_t e;
        req = r;
        a = da; b = db; c = dc; d = dd;
        dat[0] = da; dat[1] = db; dat[2] = dc; dat[3] = dd;
        model_step(r);
        e.gnt   = (m_g < 0) ? 4'b0000 : (4'b0001 << m_g);
        e.sel   = 2'(m_sel);
        e.valid = (m_g >= 0);
        e.y     = dat[m_sel];
        sb.push_back(e);
    endtask

    task automatic drive(input logic [3:0] r);
        @(negedge clk);
        apply(r, 8'h11, 8'h22, 8'h33, 8'h44);
    endtask

    // Monitor: one expected entry per clock edge that followed a stimulus.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("gnt",   int'(gnt),   int'(e.gnt));
                check("sel",   int'(sel),   int'(e.sel));
                check("valid", int'(valid), int'(e.valid));
                check("y",     int'(y),     int'(e.y));
            end
        end
    end

    initial begin
        logic [3:0] r;
        rst_n = 1'b0;
        req   = 4'b0;
        a = '0; b = '0; c = '0; d = '0;
        #12;
        check("reset_gnt",   int'(gnt),   0);
        check("reset_valid", int'(valid), 0);
        check("reset_sel",   int'(sel),   0);
        @(negedge clk);
        rst_n = 1'b1;

        // Full contention: four cycles each in pointer order, then wrap.
        repeat (17) drive(4'b1111);
        // Owner 0 leaves, 1 takes over; then 1 leaves with 0 and 3 waiting.
        drive(4'b0010);
        drive(4'b1001);
        // Sole owner leaves: idle with sel held, then a fresh pair by ptr.
        drive(4'b0000);
        drive(4'b0000);
        drive(4'b0011);
        drive(4'b0000);
        // Single requester held past the hold limit, then contention on a
        // saturated counter must rotate at once.
        repeat (10) drive(4'b0100);
        drive(4'b0101);
        drive(4'b0100);
        repeat (3) drive(4'b0100);

        // Mid-grant asynchronous reset while gnt is 0100.
        @(posedge clk);
        #3;
        check("pre_rst_gnt", int'(gnt), 4);
        rst_n = 1'b0;
        #1;
        check("async_rst_gnt",   int'(gnt),   0);
        check("async_rst_valid", int'(valid), 0);
        check("async_rst_sel",   int'(sel),   0);
        model_reset();
        req = 4'b0000;
        @(posedge clk);
        #1;
        check("rst_hold_gnt", int'(gnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        apply(4'b1111, 8'h11, 8'h22, 8'h33, 8'h44);
        repeat (5) drive(4'b1111);

        // Randomized traffic: mostly sticky requests so holds get exercised.
        r = 4'b0000;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            case ($urandom_range(0, 5))
                0:       r = 4'($urandom_range(0, 15));
                1:       r = r ^ (4'b0001 << $urandom_range(0, 3));
                default: r = r;
            endcase
            apply(r, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        end

        for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
